// File: rtl/xmem_param_pkg.sv
// rtl/xmem_param_pkg.sv - shared address-map parameters, table type and lookup response type
//
// Purpose: widths and sizes shared by the partition lookup block and its
// channel pipeline, plus the packed rangeStart table type and a helper that
// returns the exclusive end address of a partition.
package xmem_param_pkg;

  localparam int XMEM_AW            = 16;
  localparam int MAX_PARTITION      = 8;
  localparam int LOG2_MAX_PARTITION = 3;
  // Width able to hold 0..MAX_PARTITION (partition count and table index).
  localparam int PN_W               = LOG2_MAX_PARTITION + 1;

  typedef logic [MAX_PARTITION:0][XMEM_AW-1:0] range_tbl_t;

  typedef struct packed {
    logic [LOG2_MAX_PARTITION-1:0] partIdx;
    logic [XMEM_AW-1:0]            offset;
    logic                          miss;
  } part_rsp_t;

  // Partition p covers [tbl[p], tbl[p+1]); callers only pass p < MAX_PARTITION.
  function automatic logic [XMEM_AW-1:0] getRangeEnd(input range_tbl_t tbl,
                                                     input logic [PN_W-1:0] p);
    return tbl[p + PN_W'(1)];
  endfunction

endpackage

// File: rtl/xmem_part_lookup_ch.sv
// rtl/xmem_part_lookup_ch.sv - one channel of the partition lookup pipeline
//
// Purpose: stage 1 registers the address and the per-partition "below end"
// compare vector; the response stage priority-encodes that vector and
// subtracts the partition base. PIPE_OUT=1 registers the response stage.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cfg_busy      a configuration write is pending; new requests are held off
//   range_start   shared rangeStart table (read only)
//   part_num      number of programmed partitions
//   req_valid/req_adr/req_ready   request handshake
//   rsp_valid/rsp_ready/rsp       response handshake and payload
//   empty         no lookup in flight in this channel
module xmem_part_lookup_ch
  import xmem_param_pkg::*;
#(
  parameter int PIPE_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_busy,
  input  range_tbl_t         range_start,
  input  logic [PN_W-1:0]    part_num,
  input  logic               req_valid,
  input  logic [XMEM_AW-1:0] req_adr,
  output logic               req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output part_rsp_t          rsp,
  output logic               empty
);

  logic                     s1_valid;
  logic [XMEM_AW-1:0]       s1_adr;
  logic [MAX_PARTITION-1:0] s1_hit;
  logic                     s1_below;
  logic [MAX_PARTITION-1:0] hit_next;
  logic                     s1_drain;
  logic                     s1_open;
  part_rsp_t                s1_rsp;

  // hit[p]: partition p is programmed and the address lies below its end.
  always_comb begin
    hit_next = '0;
    for (int p = 0; p < MAX_PARTITION; p++) begin
      hit_next[p] = (PN_W'(p) < part_num) &&
                    (req_adr < getRangeEnd(range_start, PN_W'(p)));
    end
  end

  assign s1_open   = !s1_valid || s1_drain;
  assign req_ready = !rst && !cfg_busy && s1_open;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_adr   <= '0;
      s1_hit   <= '0;
      s1_below <= 1'b0;
    end else if (s1_open) begin
      s1_valid <= req_valid && req_ready;
      if (req_valid && req_ready) begin
        s1_adr   <= req_adr;
        s1_hit   <= hit_next;
        s1_below <= (req_adr < range_start[0]);
      end
    end
  end

  // The table cannot change while this stage is occupied (config waits for
  // all channels to empty), so reading the base here is consistent with
  // the compare captured in stage 1.
  always_comb begin
    s1_rsp = '0;
    if (s1_valid) begin
      if (s1_below || (s1_hit == '0)) begin
        s1_rsp.miss = 1'b1;
      end else begin
        // Descending scan so the lowest matching partition wins.
        for (int p = MAX_PARTITION - 1; p >= 0; p--) begin
          if (s1_hit[p]) begin
            s1_rsp.partIdx = LOG2_MAX_PARTITION'(p);
            s1_rsp.offset  = s1_adr - range_start[p];
          end
        end
      end
    end
  end

  if (PIPE_OUT != 0) begin : g_reg
    logic      r_valid;
    part_rsp_t r_rsp;

    assign s1_drain = !r_valid || rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_rsp   <= '0;
      end else if (!r_valid || rsp_ready) begin
        r_valid <= s1_valid;
        r_rsp   <= s1_rsp;
      end
    end

    assign rsp_valid = r_valid;
    assign rsp       = r_rsp;
    assign empty     = !s1_valid && !r_valid;
  end else begin : g_comb
    assign s1_drain  = rsp_ready;
    assign rsp_valid = s1_valid;
    assign rsp       = s1_rsp;
    assign empty     = !s1_valid;
  end

endmodule

// File: rtl/xmem_part_lookup.sv
// rtl/xmem_part_lookup.sv - multi-channel global-address to partition lookup
//
// Purpose: holds the rangeStart table and partition count, and runs NUM_CH
// independent lookup pipelines against the shared table. Config writes are
// accepted only once every channel has drained.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cfg_we/cfg_num_we            write table entry / partition count
//   cfg_idx, cfg_data            entry index and value (count in low bits)
//   cfg_ready                    config write taken on this edge
//   req_valid/req_adr/req_ready  per-channel request handshake
//   rsp_valid/rsp_ready          per-channel response handshake
//   rsp_partIdx/rsp_offset/rsp_miss  per-channel lookup result
module xmem_part_lookup
  import xmem_param_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int PIPE_OUT = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic                               cfg_num_we,
  input  logic [LOG2_MAX_PARTITION:0]        cfg_idx,
  input  logic [XMEM_AW-1:0]                 cfg_data,
  output logic                               cfg_ready,
  input  logic [NUM_CH-1:0]                  req_valid,
  input  logic [NUM_CH*XMEM_AW-1:0]          req_adr,
  output logic [NUM_CH-1:0]                  req_ready,
  output logic [NUM_CH-1:0]                  rsp_valid,
  input  logic [NUM_CH-1:0]                  rsp_ready,
  output logic [NUM_CH*LOG2_MAX_PARTITION-1:0] rsp_partIdx,
  output logic [NUM_CH*XMEM_AW-1:0]          rsp_offset,
  output logic [NUM_CH-1:0]                  rsp_miss
);

  range_tbl_t        range_start;
  logic [PN_W-1:0]   part_num;
  logic [PN_W-1:0]   num_sat;
  logic              cfg_busy;
  logic [NUM_CH-1:0] ch_empty;

  assign cfg_busy  = cfg_we | cfg_num_we;
  assign cfg_ready = !rst && cfg_busy && (&ch_empty);
  assign num_sat   = (cfg_data[PN_W-1:0] > PN_W'(MAX_PARTITION)) ?
                     PN_W'(MAX_PARTITION) : cfg_data[PN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_start <= '0;
      part_num    <= '0;
    end else if (cfg_ready) begin
      // Out-of-range indices complete the handshake but leave the table alone.
      if (cfg_we && (cfg_idx <= PN_W'(MAX_PARTITION))) begin
        range_start[cfg_idx] <= cfg_data;
      end
      if (cfg_num_we) begin
        part_num <= num_sat;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    part_rsp_t ch_rsp;

    xmem_part_lookup_ch #(
      .PIPE_OUT (PIPE_OUT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .cfg_busy    (cfg_busy),
      .range_start (range_start),
      .part_num    (part_num),
      .req_valid   (req_valid[c]),
      .req_adr     (req_adr[c*XMEM_AW +: XMEM_AW]),
      .req_ready   (req_ready[c]),
      .rsp_valid   (rsp_valid[c]),
      .rsp_ready   (rsp_ready[c]),
      .rsp         (ch_rsp),
      .empty       (ch_empty[c])
    );

    assign rsp_partIdx[c*LOG2_MAX_PARTITION +: LOG2_MAX_PARTITION] = ch_rsp.partIdx;
    assign rsp_offset[c*XMEM_AW +: XMEM_AW] = ch_rsp.offset;
    assign rsp_miss[c] = ch_rsp.miss;
  end

endmodule

// File: tb/tb_xmem_part_lookup.sv
// tb/tb_xmem_part_lookup.sv - directed self-checking bench for xmem_part_lookup
module tb_xmem_part_lookup;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_we, cfg_num_we;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_data;
  logic        cfg_ready;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_miss;
  logic [15:0] adr_c [2];
  logic [31:0] req_adr;
  logic [5:0]  rsp_partIdx;
  logic [31:0] rsp_offset;

  assign req_adr = {adr_c[1], adr_c[0]};

  logic        p0_cfg_ready, p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_miss;
  logic        p0_rsp_ready;
  logic [15:0] p0_req_adr, p0_rsp_offset;
  logic [2:0]  p0_rsp_partIdx;

  assign p0_rsp_ready = 1'b1;

  xmem_part_lookup #(.NUM_CH(2), .PIPE_OUT(1)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_num_we(cfg_num_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .req_valid(req_valid), .req_adr(req_adr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_partIdx(rsp_partIdx),
    .rsp_offset(rsp_offset), .rsp_miss(rsp_miss)
  );

  xmem_part_lookup #(.NUM_CH(1), .PIPE_OUT(0)) u_dut_p0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_num_we(cfg_num_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_ready(p0_cfg_ready),
    .req_valid(p0_req_valid), .req_adr(p0_req_adr), .req_ready(p0_req_ready),
    .rsp_valid(p0_rsp_valid), .rsp_ready(p0_rsp_ready), .rsp_partIdx(p0_rsp_partIdx),
    .rsp_offset(p0_rsp_offset), .rsp_miss(p0_rsp_miss)
  );

  int n_vec = 0;
  int n_bad = 0;
  int low_cnt [2];
  logic [15:0] s_adr [2][8];
  logic [19:0] s_exp [2][8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ex(input logic m, input logic [2:0] i, input logic [15:0] o);
    return {m, i, o};
  endfunction

  function automatic logic [19:0] rsp_word(input int c);
    return {rsp_miss[c], rsp_partIdx[c*3 +: 3], rsp_offset[c*16 +: 16]};
  endfunction

  function automatic logic [19:0] p0_word();
    return {p0_rsp_miss, p0_rsp_partIdx, p0_rsp_offset};
  endfunction

  task automatic cfg_wr(input logic we, input logic nwe, input logic [3:0] idx,
                        input logic [15:0] data, input string tag);
    logic seen;
    seen = 1'b0;
    cfg_we = we; cfg_num_we = nwe; cfg_idx = idx; cfg_data = data;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk); seen = cfg_ready;
      @(posedge clk); #1;
      if (seen) break;
    end
    chk(tag, seen, 1);
    cfg_we = 1'b0; cfg_num_we = 1'b0;
  endtask

  // sel=1 targets the PIPE_OUT=0 instance, otherwise channel 0 of the main one.
  task automatic do_lookup(input logic sel, input logic [15:0] adr, input logic [19:0] exp,
                           input int elat, input string tag);
    logic rdy, v;
    int   lat;
    rdy = 1'b0; v = 1'b0; lat = 0;
    if (sel) begin p0_req_valid = 1'b1; p0_req_adr = adr; end
    else begin req_valid[0] = 1'b1; adr_c[0] = adr; end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); rdy = sel ? p0_req_ready : req_ready[0];
      @(posedge clk); #1;
      if (rdy) break;
    end
    chk({tag, "_acc"}, rdy, 1);
    p0_req_valid = 1'b0; req_valid[0] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk); v = sel ? p0_rsp_valid : rsp_valid[0];
      if (v) begin lat = t; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_rsp"}, sel ? p0_word() : rsp_word(0), exp);
    @(posedge clk); #1;
  endtask

  task automatic produce(input int c);
    int   i;
    logic rdy;
    i = 0;
    for (int t = 0; t < 100 && i < 8; t++) begin
      req_valid[c] = 1'b1; adr_c[c] = s_adr[c][i];
      @(negedge clk); rdy = req_ready[c];
      if (!rdy) low_cnt[c]++;
      @(posedge clk); #1;
      if (rdy) i++;
    end
    req_valid[c] = 1'b0;
    chk($sformatf("s26_sent%0d", c), i, 8);
  endtask

  task automatic consume(input int c);
    int k, first, last;
    k = 0; first = -1; last = -1;
    for (int t = 0; t < 100 && k < 8; t++) begin
      @(negedge clk);
      if (rsp_valid[c]) begin
        chk($sformatf("s26_ch%0d_r%0d", c, k), rsp_word(c), s_exp[c][k]);
        if (rsp_ready[c]) begin
          if (first < 0) first = t;
          last = t;
          k++;
        end
      end
      @(posedge clk); #1;
      if (c == 0 && t == 4) rsp_ready[0] = 1'b1;
    end
    chk($sformatf("s26_rcv%0d", c), k, 8);
    if (c == 1) chk("s26_ch1_rate", last - first, 7);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   got;
    rst = 1'b1; cfg_we = 1'b1; cfg_num_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    req_valid = '0; adr_c[0] = '0; adr_c[1] = '0; rsp_ready = 2'b11;
    p0_req_valid = 1'b0; p0_req_adr = '0;
    low_cnt[0] = 0; low_cnt[1] = 0;

    s_adr[0] = '{16'h000, 16'h050, 16'h0FF, 16'h100, 16'h200, 16'h2FF, 16'h300, 16'h7FF};
    s_exp[0] = '{ex(0,0,16'h000), ex(0,0,16'h050), ex(0,0,16'h0FF), ex(0,1,16'h000),
                 ex(0,1,16'h100), ex(0,1,16'h1FF), ex(0,2,16'h000), ex(0,2,16'h4FF)};
    s_adr[1] = '{16'h010, 16'h110, 16'h310, 16'h810, 16'h120, 16'h000, 16'h2FF, 16'h800};
    s_exp[1] = '{ex(0,0,16'h010), ex(0,1,16'h010), ex(0,2,16'h010), ex(1,0,16'h000),
                 ex(0,1,16'h020), ex(0,0,16'h000), ex(0,1,16'h1FF), ex(1,0,16'h000)};

    // reset state, with a config write request pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_miss", rsp_miss, 0);
    chk("rst_rsp_offset", rsp_offset, 0);
    chk("rst_rsp_idx", rsp_partIdx, 0);
    chk("rst_p0_out", {p0_rsp_valid, p0_rsp_miss, p0_req_ready, p0_cfg_ready}, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0; rst = 1'b0;

    // partNum == 0 misses everything
    do_lookup(0, 16'h000, ex(1,0,0), 2, "pn0_main");
    do_lookup(1, 16'h000, ex(1,0,0), 1, "pn0_p0");

    cfg_wr(1, 0, 4'd1, 16'h100, "cfg_e1");
    cfg_wr(1, 0, 4'd2, 16'h300, "cfg_e2");
    cfg_wr(1, 0, 4'd3, 16'h800, "cfg_e3");
    // entry 0 and count in one write: rangeStart[0]=0x43, partNum=3
    cfg_wr(1, 1, 4'd0, 16'h043, "cfg_both");
    do_lookup(0, 16'h042, ex(1,0,0), 2, "both_below");
    do_lookup(0, 16'h043, ex(0,0,0), 2, "both_base");

    cfg_wr(1, 0, 4'd0, 16'h040, "cfg_e0_40");
    do_lookup(0, 16'h03F, ex(1,0,0), 2, "lo_3f");
    do_lookup(0, 16'h040, ex(0,0,0), 2, "lo_40");
    cfg_wr(1, 0, 4'd0, 16'h000, "cfg_e0_0");

    // reference table {0,0x100,0x300,0x800}, partNum=3
    do_lookup(0, 16'h0FF, ex(0,0,16'h0FF), 2, "m_0ff");
    do_lookup(0, 16'h100, ex(0,1,16'h000), 2, "m_100");
    do_lookup(0, 16'h7FF, ex(0,2,16'h4FF), 2, "m_7ff");
    do_lookup(0, 16'h800, ex(1,0,16'h000), 2, "m_800");
    do_lookup(1, 16'h0FF, ex(0,0,16'h0FF), 1, "p0_0ff");
    do_lookup(1, 16'h100, ex(0,1,16'h000), 1, "p0_100");
    do_lookup(1, 16'h7FF, ex(0,2,16'h4FF), 1, "p0_7ff");
    do_lookup(1, 16'h800, ex(1,0,16'h000), 1, "p0_800");

    // out-of-range index is acknowledged but ignored
    cfg_wr(1, 0, 4'd9, 16'hABC, "cfg_idx9");
    do_lookup(0, 16'h0FF, ex(0,0,16'h0FF), 2, "idx9_0ff");

    // count 9 saturates to 8, exposing partition 3 = [0x800,0x900)
    cfg_wr(1, 0, 4'd4, 16'h900, "cfg_e4");
    cfg_wr(0, 1, 4'd0, 16'h009, "cfg_n9");
    do_lookup(0, 16'h850, ex(0,3,16'h050), 2, "sat_850");
    cfg_wr(0, 1, 4'd0, 16'h003, "cfg_n3");
    do_lookup(0, 16'h850, ex(1,0,16'h000), 2, "n3_850");

    // ch0 back-pressured for 5 cycles while ch1 streams at full rate
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b1;
    fork
      produce(0);
      produce(1);
      consume(0);
      consume(1);
    join
    chk("s26_ch0_bp", low_cnt[0] > 0, 1);
    chk("s26_ch1_nobp", low_cnt[1], 0);
    rsp_ready = 2'b11;
    @(posedge clk); #1;

    // config write waits for two in-flight lookups to drain
    rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; adr_c[0] = 16'h050;
    @(negedge clk); chk("c27_rdy_a", req_ready[0], 1);
    @(posedge clk); #1; adr_c[0] = 16'h150;
    @(negedge clk); chk("c27_rdy_b", req_ready[0], 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; cfg_we = 1'b1; cfg_idx = 4'd1; cfg_data = 16'h200;
    got = 0; seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (cfg_ready) begin seen = 1'b1; break; end
      if (rsp_valid[0] && rsp_ready[0]) begin
        chk($sformatf("c27_rsp%0d", got), rsp_word(0),
            (got == 0) ? ex(0,0,16'h050) : ex(0,1,16'h050));
        got++;
      end
      @(posedge clk); #1;
      if (t == 2) rsp_ready[0] = 1'b1;
    end
    chk("c27_cfg_seen", seen, 1);
    chk("c27_drained", got, 2);
    chk("c27_vld_at_cfg", rsp_valid[0], 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    do_lookup(0, 16'h1FF, ex(0,0,16'h1FF), 2, "c27_after");

    // reset with two lookups in flight
    req_valid[0] = 1'b1; adr_c[0] = 16'h010;
    @(posedge clk); #1; adr_c[0] = 16'h020;
    @(posedge clk); #1; req_valid[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("r28_rst_vld", rsp_valid, 0);
    chk("r28_rst_rdy", req_ready, 0);
    chk("r28_rst_miss", rsp_miss, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("r28_rdy_after", req_ready, 2'b11);
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("r28_no_rsp%0d", t), rsp_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    do_lookup(0, 16'h000, ex(1,0,0), 2, "r28_pn0");
    cfg_wr(0, 1, 4'd0, 16'h003, "r28_n3");
    do_lookup(0, 16'h000, ex(1,0,0), 2, "r28_tbl0_000");
    do_lookup(0, 16'h100, ex(1,0,0), 2, "r28_tbl0_100");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
